// File: rtl/sata_fifo_pkg.sv
// Shared types and helpers for the SATA receive FIFO controllers.
// Pointer width is fixed to match gray_comparator.
package sata_fifo_pkg;

  localparam int PTR_BITS = 3;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HOLD_WAIT = 2'd1,
    HELD      = 2'd2,
    RESUME    = 2'd3
  } wr_ctrl_state_t;

  function automatic logic [PTR_BITS-1:0] bin2gray(input logic [PTR_BITS-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/sata_fifo_wr_ctrl_gray_counter.sv
// Binary + Gray register pair with increment enable; shared by both FIFO sides.
// Both registers advance together so the Gray copy never lags the binary one.
module gray_counter
  import sata_fifo_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  output logic [PTR_BITS-1:0] bin,
  output logic [PTR_BITS-1:0] gray
);

  logic [PTR_BITS-1:0] bin_next;

  assign bin_next = bin + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin  <= '0;
      gray <= '0;
    end else if (inc) begin
      bin  <= bin_next;
      gray <= bin2gray(bin_next);
    end
  end

endmodule

// File: rtl/sata_fifo_wr_ctrl.sv
// Write-side controller for the SATA receive FIFO: Gray write pointer, overrun
// accounting and a HOLD/resume FSM with low-watermark hysteresis (RESUME_GUARD in 1..15).
module sata_fifo_wr_ctrl #(
  parameter int PTR_BITS     = 3,
  parameter int RESUME_GUARD = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                wr_en,
  output logic [PTR_BITS-1:0] wr_addr,
  output logic [PTR_BITS-1:0] cnt_wr,
  input  logic                high,
  input  logic                low,
  input  logic                full,
  input  logic                empty,
  output logic                hold_req,
  input  logic                hold_ack,
  output logic                overflow,
  output logic [7:0]          drop_cnt,
  input  logic                clr_overflow
);

  import sata_fifo_pkg::*;

  localparam logic [3:0] GUARD_LOAD = 4'(RESUME_GUARD - 1);

  wr_ctrl_state_t      state, state_next;
  logic [3:0]          guard, guard_next;
  logic [PTR_BITS-1:0] wr_bin;
  logic                drop;
  logic                low_eff;

  assign in_ready = ~full;
  assign wr_en    = in_valid & ~full;
  assign drop     = in_valid & full;
  assign wr_addr  = wr_bin;
  assign low_eff  = low & ~high;

  gray_counter u_wr_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (wr_en),
    .bin  (wr_bin),
    .gray (cnt_wr)
  );

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_overflow)
        drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      guard    <= 4'd0;
      hold_req <= 1'b0;
    end else begin
      state    <= state_next;
      guard    <= guard_next;
      hold_req <= (state_next != RUN);
    end
  end

  // guard holds the number of low cycles still required, counting the current one,
  // so HOLD is released on the edge ending the RESUME_GUARD-th consecutive low cycle.
  always_comb begin
    state_next = state;
    guard_next = guard;
    case (state)
      RUN: begin
        if (high)
          state_next = HOLD_WAIT;
      end
      HOLD_WAIT: begin
        if (low_eff) begin
          state_next = (RESUME_GUARD <= 1) ? RUN : RESUME;
          guard_next = GUARD_LOAD;
        end else if (hold_ack) begin
          state_next = HELD;
        end
      end
      HELD: begin
        if (low_eff) begin
          state_next = (RESUME_GUARD <= 1) ? RUN : RESUME;
          guard_next = GUARD_LOAD;
        end
      end
      RESUME: begin
        if (!low_eff) begin
          state_next = HELD;
        end else if (guard <= 4'd1) begin
          state_next = RUN;
          guard_next = 4'd0;
        end else begin
          guard_next = guard - 4'd1;
        end
      end
      default: begin
        state_next = RUN;
        guard_next = 4'd0;
      end
    endcase
  end

  // The comparator can never report both flags; that would mean a corrupt pointer.
  assert property (@(posedge clk) disable iff (rst) !(empty && full));

endmodule

// File: tb/tb_sata_fifo_wr_ctrl.sv
// Self-checking bench for sata_fifo_wr_ctrl: scenario tasks with a queue of
// expected results pushed at stimulus time and popped when the DUT responds.
module tb_sata_fifo_wr_ctrl;

  localparam int PTR_BITS = 3;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic                wr_en;
  logic [PTR_BITS-1:0] wr_addr;
  logic [PTR_BITS-1:0] cnt_wr;
  logic                high, low, full, empty;
  logic                hold_req;
  logic                hold_ack;
  logic                overflow;
  logic [7:0]          drop_cnt;
  logic                clr_overflow;

  int passed = 0;
  int total  = 0;
  int exp_q[$];

  sata_fifo_wr_ctrl #(.PTR_BITS(PTR_BITS), .RESUME_GUARD(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .cnt_wr       (cnt_wr),
    .high         (high),
    .low          (low),
    .full         (full),
    .empty        (empty),
    .hold_req     (hold_req),
    .hold_ack     (hold_ack),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .clr_overflow (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int e;
    #1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    e = exp_q.pop_front(); total++;
    if (hold_req !== e[0]) $display("[TB] FAIL reset_hold_req: got %0d expected %0d", hold_req, e);
    else passed++;
    e = exp_q.pop_front(); total++;
    if (overflow !== e[0]) $display("[TB] FAIL reset_overflow: got %0d expected %0d", overflow, e);
    else passed++;
    e = exp_q.pop_front(); total++;
    if (drop_cnt !== e[7:0]) $display("[TB] FAIL reset_drop_cnt: got %0d expected %0d", drop_cnt, e);
    else passed++;
    e = exp_q.pop_front(); total++;
    if (cnt_wr !== e[2:0]) $display("[TB] FAIL reset_cnt_wr: got %b expected %b", cnt_wr, e[2:0]);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    int gray_tab[9] = '{1, 3, 2, 6, 7, 5, 4, 0, 1};
    int e;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      exp_q.push_back(i % 8);
      exp_q.push_back(gray_tab[i]);
      #1;
      total++;
      if (wr_en !== 1'b1) $display("[TB] FAIL wrap_wr_en[%0d]: got %0d expected 1", i, wr_en);
      else passed++;
      e = exp_q.pop_front(); total++;
      if (wr_addr !== e[2:0]) $display("[TB] FAIL wrap_addr[%0d]: got %0d expected %0d", i, wr_addr, e);
      else passed++;
      tick();
      e = exp_q.pop_front(); total++;
      if (cnt_wr !== e[2:0]) $display("[TB] FAIL wrap_cnt_wr[%0d]: got %b expected %b", i, cnt_wr, e[2:0]);
      else passed++;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_hold(input string name, input logic exp);
    exp_q.push_back(int'(exp));
    total++;
    if (hold_req !== exp_q[0][0]) $display("[TB] FAIL %s: got hold_req=%0d expected %0d", name, hold_req, exp_q[0]);
    else passed++;
    void'(exp_q.pop_front());
  endtask

  task automatic test_hold_cycle();
    hold_ack = 1'b1;
    tick();
    hold_ack = 1'b0;
    check_hold("ack_ignored_in_run", 1'b0);
    high = 1'b1;
    tick();
    high = 1'b0;
    check_hold("hold_rise", 1'b1);
    hold_ack = 1'b1;
    tick();
    hold_ack = 1'b0;
    check_hold("held_after_ack", 1'b1);
    high = 1'b1; low = 1'b1;
    tick(); tick();
    high = 1'b0;
    check_hold("high_over_low", 1'b1);
    tick();
    check_hold("release_first_low", 1'b1);
    tick();
    low = 1'b0;
    check_hold("release_second_low", 1'b0);
  endtask

  task automatic test_low_glitch();
    high = 1'b1;
    tick();
    high = 1'b0; hold_ack = 1'b1;
    tick();
    hold_ack = 1'b0;
    low = 1'b1;
    tick();
    low = 1'b0;
    check_hold("glitch_low1", 1'b1);
    tick();
    check_hold("glitch_back_held", 1'b1);
    low = 1'b1;
    tick();
    check_hold("glitch_relow1", 1'b1);
    tick();
    low = 1'b0;
    check_hold("glitch_release", 1'b0);
  endtask

  task automatic test_drain_before_ack();
    high = 1'b1;
    tick();
    high = 1'b0;
    low = 1'b1; hold_ack = 1'b1;
    tick();
    hold_ack = 1'b0;
    check_hold("drain_enter_resume", 1'b1);
    tick();
    low = 1'b0;
    check_hold("drain_release", 1'b0);
  endtask

  task automatic test_overrun();
    int e;
    full = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(i + 1);
      #1;
      total++;
      if (wr_en !== 1'b0 || in_ready !== 1'b0)
        $display("[TB] FAIL overrun_wr_en[%0d]: got wr_en=%0d in_ready=%0d expected 0/0", i, wr_en, in_ready);
      else passed++;
      tick();
      e = exp_q.pop_front(); total++;
      if (overflow !== 1'b1 || drop_cnt !== e[7:0])
        $display("[TB] FAIL overrun_cnt[%0d]: got ovf=%0d cnt=%0d expected 1/%0d", i, overflow, drop_cnt, e);
      else passed++;
    end
    total++;
    if (cnt_wr !== 3'b001) $display("[TB] FAIL overrun_no_write: got %b expected 001", cnt_wr);
    else passed++;
    clr_overflow = 1'b1;
    exp_q.push_back(1);
    tick();
    e = exp_q.pop_front(); total++;
    if (overflow !== 1'b1 || drop_cnt !== e[7:0])
      $display("[TB] FAIL clear_vs_drop: got ovf=%0d cnt=%0d expected 1/%0d", overflow, drop_cnt, e);
    else passed++;
    in_valid = 1'b0;
    tick();
    clr_overflow = 1'b0;
    total++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0)
      $display("[TB] FAIL clear_only: got ovf=%0d cnt=%0d expected 0/0", overflow, drop_cnt);
    else passed++;
    in_valid = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    in_valid = 1'b0;
    total++;
    if (drop_cnt !== 8'd255) $display("[TB] FAIL drop_saturate: got %0d expected 255", drop_cnt);
    else passed++;
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    full = 1'b0;
  endtask

  task automatic test_async_reset();
    high = 1'b1;
    tick();
    high = 1'b0; hold_ack = 1'b1;
    tick();
    hold_ack = 1'b0;
    in_valid = 1'b1;
    tick();
    full = 1'b1;
    tick();
    full = 1'b0; in_valid = 1'b0;
    total++;
    if (hold_req !== 1'b1 || overflow !== 1'b1 || cnt_wr !== 3'b011)
      $display("[TB] FAIL pre_reset_state: got hold=%0d ovf=%0d cnt_wr=%b expected 1/1/011", hold_req, overflow, cnt_wr);
    else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (hold_req !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0 || cnt_wr !== 3'b000)
      $display("[TB] FAIL async_reset: got hold=%0d ovf=%0d cnt=%0d cnt_wr=%b expected 0/0/0/000", hold_req, overflow, drop_cnt, cnt_wr);
    else passed++;
    #2;
    rst = 1'b0;
    in_valid = 1'b1;
    exp_q.push_back(1);
    #1;
    total++;
    if (wr_addr !== 3'd0) $display("[TB] FAIL post_reset_addr: got %0d expected 0", wr_addr);
    else passed++;
    tick();
    in_valid = 1'b0;
    total++;
    if (cnt_wr !== exp_q[0][2:0]) $display("[TB] FAIL post_reset_cnt_wr: got %b expected %b", cnt_wr, exp_q[0][2:0]);
    else passed++;
    void'(exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; high = 1'b0; low = 1'b0; full = 1'b0; empty = 1'b0;
    hold_ack = 1'b0; clr_overflow = 1'b0;
    test_reset();
    test_wrap();
    test_hold_cycle();
    test_low_glitch();
    test_drain_before_ack();
    test_overrun();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
